// File: rtl/fetch_queue.sv
// fetch_queue: prefetching fetch stage; issues sequential reads and buffers {pc, insn} pairs for decode.
// Latency: a response accepted at edge N is presented on insn_valid_o/pc_o/insn_o after edge N (no bypass).
// Backpressure: requests issue only while occupancy + in-flight reads < DEPTH; decode throttles via insn_ready_i.
//
// Ports:
//   clk, rst                    clock and synchronous active-low reset
//   req_valid_o/req_addr_o      memory read request (req_ready_i accepts)
//   resp_valid_i/resp_data_i    in-order read data
//   redirect_i/redirect_pc_i    flush buffer, drop in-flight reads, restart at word-aligned PC
//   insn_valid_o/insn_ready_i   head-of-queue handshake to decode; pc_o/insn_o are 0 when empty
// Optional: define FETCHQ_PERF_EN to add perf_flush_o (redirect count) and perf_stall_o (empty-cycle count).
module fetch_queue #(
    parameter int                AWIDTH          = 32,
    parameter int                DWIDTH          = 32,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [AWIDTH-1:0] RESET_PC        = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              resp_valid_i,
    input  logic [DWIDTH-1:0] resp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]       perf_flush_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     discard;
    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] resp_pc;

    logic [SW-1:0]     inflight;
    logic [AWIDTH-1:0] redirect_tgt;
    logic              issue;
    logic              resp_acc;
    logic              drop;
    logic              push;
    logic              pop;

    // Reserving a slot for every in-flight read means a response can always be pushed.
    assign inflight     = SW'(count) + SW'(outstanding);
    assign req_valid_o  = !redirect_i && (inflight < SW'(DEPTH))
                          && (outstanding < OW'(MAX_OUTSTANDING));
    assign req_addr_o   = fetch_pc;
    assign redirect_tgt = redirect_pc_i & ~AWIDTH'(3);

    assign issue    = req_valid_o && req_ready_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_acc = resp_valid_i && (outstanding != '0);
    assign drop     = resp_acc && (discard != '0);
    assign push     = resp_acc && (discard == '0);
    assign pop      = insn_valid_o && insn_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            // issue is already suppressed during a redirect, so this holds in both cases.
            case ({issue, resp_acc})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase

            if (redirect_i) begin
                fetch_pc <= redirect_tgt;
                resp_pc  <= redirect_tgt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                // Every read still in flight after this edge belongs to the old stream.
                // Reads already marked for discard are a subset of them, so the new
                // discard count is simply what remains outstanding; a response arriving
                // now is dropped as well. This keeps back-to-back redirects exact.
                discard  <= outstanding - OW'(resp_acc);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + AWIDTH'(4);
                end
                if (drop) begin
                    discard <= discard - OW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + AWIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (rst && !redirect_i && push) begin
            mem[wr_ptr] <= '{pc: resp_pc, insn: resp_data_i};
        end
    end

    assign insn_valid_o = (count != '0);
    assign pc_o         = insn_valid_o ? mem[rd_ptr].pc   : '0;
    assign insn_o       = insn_valid_o ? mem[rd_ptr].insn : '0;

`ifdef FETCHQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_flush_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (redirect_i && (perf_flush_o != 32'hFFFF_FFFF)) begin
                perf_flush_o <= perf_flush_o + 32'd1;
            end
            if (!insn_valid_o && (perf_stall_o != 32'hFFFF_FFFF)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam logic [31:0] MAGIC    = 32'hA5A5_A5A5;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clk;
    logic        rst;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        insn_valid_o;
    logic        insn_ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
`ifdef FETCHQ_PERF_EN
    logic [31:0] perf_flush_o;
    logic [31:0] perf_stall_o;
`endif

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .resp_valid_i (resp_valid_i),
        .resp_data_i  (resp_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .insn_valid_o (insn_valid_o),
        .insn_ready_i (insn_ready_i),
        .pc_o         (pc_o),
        .insn_o       (insn_o)
`ifdef FETCHQ_PERF_EN
        ,
        .perf_flush_o (perf_flush_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];     // memory model: accepted requests awaiting response
    logic [31:0] exp_q[$];    // scoreboard: expected pc of each popped entry

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    int issued   = 0;
    int issue_limit = 0;

    bit          s_rst      = 0;
    bit          s_req_en   = 0;
    bit          s_insn_rdy = 0;
    bit          s_redir    = 0;
    logic [31:0] s_rpc      = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // One cycle: apply inputs at the falling edge, then let the memory model
    // observe whether a request will be accepted at the next rising edge.
    task automatic tick();
        pend_t p;
        @(negedge clk);
        rst           = s_rst;
        redirect_i    = s_redir;
        redirect_pc_i = s_rpc;
        insn_ready_i  = s_insn_rdy;
        req_ready_i   = s_req_en && (issued < issue_limit);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_valid_i = 1'b1;
            resp_data_i  = pend[0].addr ^ MAGIC;
            void'(pend.pop_front());
        end else begin
            resp_valid_i = 1'b0;
            resp_data_i  = '0;
        end
        #1;
        if (rst && req_valid_o && req_ready_i) begin
            p.addr = req_addr_o;
            p.due  = cyc + lat;
            pend.push_back(p);
            issued++;
        end
        cyc++;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || pend.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({name, "_drained"}, 32'(n < bound), 32'd1);
        chk({name, "_empty_after"}, 32'(insn_valid_o), 32'd0);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && !redirect_i && insn_valid_o && insn_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got pc %h expected no entry", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", pc_o, e);
                    chk("pop_insn", insn_o, e ^ MAGIC);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int gaps;
`ifdef FETCHQ_PERF_EN
        logic [31:0] st0;
`endif
        rst = 0; req_ready_i = 0; resp_valid_i = 0; resp_data_i = '0;
        redirect_i = 0; redirect_pc_i = '0; insn_ready_i = 0;

        // Reset values
        tick(); tick();
        s_rst = 1;
        tick();
        chk("rst_req_valid", 32'(req_valid_o), 32'd1);
        chk("rst_req_addr", req_addr_o, RESET_PC);
        chk("rst_insn_valid", 32'(insn_valid_o), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_insn", insn_o, 32'd0);

        // Streaming with 1-cycle memory: in-order, no gaps after warm-up
        push_seq(RESET_PC, 12);
        issued = 0; issue_limit = 12;
        s_req_en = 1; s_insn_rdy = 1;
        seen = 0; gaps = 0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            tick();
            if (insn_valid_o) seen = 1;
            else if (seen != 0 && exp_q.size() != 0) gaps++;
        end
        chk("stream_gaps", 32'(gaps), 32'd0);
        drain("stream", 40);

        // Decode backpressure: exactly DEPTH entries, requests stop
        s_insn_rdy = 0;
        issued = 0; issue_limit = 8;
        repeat (20) tick();
        chk("bp_issued", 32'(issued), 32'd4);
        chk("bp_req_valid", 32'(req_valid_o), 32'd0);
        chk("bp_insn_valid", 32'(insn_valid_o), 32'd1);
        chk("bp_head_pc", pc_o, 32'h0100_0030);
        push_seq(32'h0100_0030, 8);
        s_insn_rdy = 1;
        drain("bp", 60);

        // Redirect with two reads in flight and entries buffered
        lat = 3; s_insn_rdy = 0;
        issued = 0; issue_limit = 1000;
        repeat (6) tick();
        chk("rd_setup_outstanding", 32'(pend.size()), 32'd2);
        chk("rd_setup_valid", 32'(insn_valid_o), 32'd1);
        push_seq(32'h0100_0200, 4);
        issue_limit = issued + 4;
        s_redir = 1; s_rpc = 32'h0100_0203;
        tick();
        chk("rd_req_blocked", 32'(req_valid_o), 32'd0);
        s_redir = 0; s_insn_rdy = 1;
        tick();
        chk("rd_flush_empty", 32'(insn_valid_o), 32'd0);
        drain("rd", 60);

        // Redirect coinciding with a response and a decode pop
        s_insn_rdy = 0;
        issued = 0; issue_limit = 1000;
        repeat (7) tick();
        push_seq(32'h0100_0400, 4);
        issue_limit = issued + 4;
        s_redir = 1; s_rpc = 32'h0100_0402; s_insn_rdy = 1;
        tick();
        chk("rd2_pre_valid", 32'(insn_valid_o), 32'd1);
        chk("rd2_resp_same_cycle", 32'(resp_valid_i), 32'd1);
        s_redir = 0;
        tick();
        chk("rd2_flush_empty", 32'(insn_valid_o), 32'd0);
        drain("rd2", 60);

        // Reset mid-stream with two reads in flight; late responses ignored
        s_insn_rdy = 0;
        issued = 0; issue_limit = 1000;
        repeat (6) tick();
        chk("mrst_setup_outstanding", 32'(pend.size()), 32'd2);
        s_rst = 0;
        tick();
        s_rst = 1; s_req_en = 0;
        tick();
        chk("mrst_req_valid", 32'(req_valid_o), 32'd1);
        chk("mrst_req_addr", req_addr_o, RESET_PC);
        chk("mrst_insn_valid", 32'(insn_valid_o), 32'd0);
        chk("mrst_pc", pc_o, 32'd0);
        chk("mrst_insn", insn_o, 32'd0);
        tick(); tick();
        chk("mrst_late_ignored", 32'(insn_valid_o), 32'd0);
        chk("mrst_late_done", 32'(pend.size()), 32'd0);
        lat = 1;
        push_seq(RESET_PC, 3);
        issued = 0; issue_limit = 3;
        s_req_en = 1; s_insn_rdy = 1;
        drain("mrst", 40);

`ifdef FETCHQ_PERF_EN
        s_req_en = 0;
        tick();
        st0 = perf_stall_o;
        repeat (10) tick();
        chk("perf_stall_delta", perf_stall_o - st0, 32'd10);
        for (int i = 0; i < 3; i++) begin
            s_redir = 1; s_rpc = 32'h0100_0800;
            tick();
            s_redir = 0;
            tick();
        end
        tick();
        chk("perf_flush", perf_flush_o, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
